// File: rtl/mem_resp_ws_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the FSM state encoding, the out-of-range read pattern and the latency counter sizing.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] RANGE_ERR_DATA = 32'hDEAD_BEEF;

  // 4-bit base + 4-bit extra needs one carry bit
  localparam int CNT_W = 5;

  function automatic logic [CNT_W-1:0] load_count(input logic [3:0] base_lat,
                                                  input logic [3:0] extra);
    return {1'b0, base_lat} + {1'b0, extra} - 5'd1;
  endfunction

endpackage

// File: rtl/mem_resp_ws_if.sv
// Data-bus handshake between memory_ctrl (master) and the wait-state responder (slave).
interface mem_resp_ws_if;
  logic [31:0] address;
  logic        read_enable;
  logic [31:0] read_data;
  logic        read_ack;
  logic        write_enable;
  logic [3:0]  write_byte_enable;
  logic [31:0] write_data;
  logic        write_ack;
  logic [3:0]  extra_wait;
  logic        error;

  modport master (
    output address, read_enable, write_enable, write_byte_enable, write_data, extra_wait,
    input  read_data, read_ack, write_ack, error
  );

  modport slave (
    input  address, read_enable, write_enable, write_byte_enable, write_data, extra_wait,
    output read_data, read_ack, write_ack, error
  );
endinterface

// File: rtl/mem_resp_ws_array.sv
// Word storage with a byte-masked synchronous write port and a registered read port.
// No reset: contents survive reset, and the read register holds until the next read strobe.
module mem_resp_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-masked write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read register, loaded only on a read strobe
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_idx];
    end
  end

endmodule

// File: rtl/mem_resp_ws.sv
// Wait-state memory responder: accepts one access at a time, acks it after a
// programmable latency, and flags out-of-range or read/write-conflict accesses.
module mem_resp_ws
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  mem_resp_ws_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  RD_LAT  = 4'(READ_LATENCY);
  localparam logic [3:0]  WR_LAT  = 4'(WRITE_LATENCY);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, load_s;
  logic             accept_s, enter_ack_s;

  logic [31:0]      addr_r, wdata_r;
  logic [3:0]       be_r;
  logic             is_wr_r, conflict_r;

  logic [31:0]      cur_addr_s, cur_wdata_s, idx_s;
  logic [3:0]       cur_be_s;
  logic             cur_wr_s, cur_conflict_s, in_range_s;
  logic             wr_stb_s, rd_stb_s;

  logic             read_ack_r, write_ack_r, error_r, rd_valid_r, rd_oor_r;
  logic [31:0]      arr_rdata_s;

  assign accept_s = (state_r == IDLE) && (bus.read_enable || bus.write_enable);
  assign load_s   = load_count(bus.write_enable ? WR_LAT : RD_LAT, bus.extra_wait);

  // A zero-length access goes IDLE->ACK in one edge, so it must use the live bus fields
  always_comb begin
    if (state_r == IDLE) begin
      cur_addr_s     = bus.address;
      cur_wdata_s    = bus.write_data;
      cur_be_s       = bus.write_byte_enable;
      cur_wr_s       = bus.write_enable;
      cur_conflict_s = bus.read_enable && bus.write_enable;
    end else begin
      cur_addr_s     = addr_r;
      cur_wdata_s    = wdata_r;
      cur_be_s       = be_r;
      cur_wr_s       = is_wr_r;
      cur_conflict_s = conflict_r;
    end
  end

  assign idx_s      = (cur_addr_s - BASE_ADDR) >> 2;
  assign in_range_s = idx_s < DEPTH_L;
  assign wr_stb_s   = enter_ack_s && cur_wr_s && in_range_s;
  assign rd_stb_s   = enter_ack_s && !cur_wr_s && in_range_s;

  // Next-state and latency counter
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    enter_ack_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_s = load_s;
          if (load_s != {CNT_W{1'b0}}) begin
            state_s = WAIT;
          end else begin
            state_s     = ACK;
            enter_ack_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_s     = ACK;
          enter_ack_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      ACK: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, request latches and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      addr_r      <= 32'h0;
      wdata_r     <= 32'h0;
      be_r        <= 4'h0;
      is_wr_r     <= 1'b0;
      conflict_r  <= 1'b0;
      read_ack_r  <= 1'b0;
      write_ack_r <= 1'b0;
      error_r     <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_oor_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        addr_r     <= bus.address;
        wdata_r    <= bus.write_data;
        be_r       <= bus.write_byte_enable;
        is_wr_r    <= bus.write_enable;
        conflict_r <= bus.read_enable && bus.write_enable;
      end
      read_ack_r  <= enter_ack_s && !cur_wr_s;
      write_ack_r <= enter_ack_s && cur_wr_s;
      error_r     <= enter_ack_s && (!in_range_s || cur_conflict_s);
      if (enter_ack_s && !cur_wr_s) begin
        rd_valid_r <= 1'b1;
        rd_oor_r   <= !in_range_s;
      end
    end
  end

  mem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_stb_s),
    .wr_idx  (idx_s[AW-1:0]),
    .wr_be   (cur_be_s),
    .wr_data (cur_wdata_s),
    .rd_en   (rd_stb_s),
    .rd_idx  (idx_s[AW-1:0]),
    .rd_data (arr_rdata_s)
  );

  assign bus.read_ack  = read_ack_r;
  assign bus.write_ack = write_ack_r;
  assign bus.error     = error_r;
  assign bus.read_data = rd_valid_r ? (rd_oor_r ? RANGE_ERR_DATA : arr_rdata_s) : 32'h0;

endmodule
